// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port, decode handshake and redirect from execute.
// The master side is the fetch unit; the slave side is the ROM/decode/execute environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 13
);
    logic              rom_cs;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_rd;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output rom_cs, rom_addr, instr_out, pc_out, instr_valid,
        input  rom_rd, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  rom_cs, rom_addr, instr_out, pc_out, instr_valid,
        output rom_rd, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, ROM chip-select/address and a small prefetch queue
// presenting {pc, instr} to decode over valid/ready; redirect reloads the PC and flushes.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 13,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                DEPTH     = 2,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] qpc_q  [DEPTH];
    logic [31:0]       qins_q [DEPTH];

    logic valid, pop, fetch_en;

    assign valid    = (count_q != '0);
    assign pop      = valid && bus.instr_ready;
    assign fetch_en = rst_n && !bus.redirect && ((count_q < CNT_W'(DEPTH)) || pop);

    assign bus.rom_cs      = fetch_en;
    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr_out   = valid ? qins_q[rd_ptr_q] : NOP_INSTR;
    assign bus.pc_out      = valid ? qpc_q[rd_ptr_q]  : '0;

    // Storage is written only on an issued fetch, so an undriven rom_rd never lands here.
    always_ff @(posedge clk) begin
        if (fetch_en) begin
            qpc_q[wr_ptr_q]  <= pc_q;
            qins_q[wr_ptr_q] <= bus.rom_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC & PC_MASK;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect) begin
            pc_q     <= bus.redirect_pc & PC_MASK;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fetch_en) begin
                pc_q     <= pc_q + ADDR_W'(4);
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CNT_W'(fetch_en) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue-based reference model checked every cycle,
// plus literal expectations from hand-worked sequences (stream, backpressure, redirect, wrap).
module tb_instr_fetch_unit;
    localparam int          AW    = 13;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_key;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(AW)) bus ();
    instr_fetch_unit_if #(.ADDR_W(AW)) wbus ();

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(13'h0000), .DEPTH(DEPTH), .NOP_INSTR(NOP))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(13'h1FF8), .DEPTH(DEPTH), .NOP_INSTR(NOP))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));

    function automatic logic [31:0] romw(logic [AW-1:0] a);
        return {19'd0, a} ^ rom_key;
    endfunction

    assign bus.rom_rd       = bus.rom_cs ? romw(bus.rom_addr) : 32'hzzzz_zzzz;
    assign wbus.rom_rd      = wbus.rom_cs ? romw(wbus.rom_addr) : 32'hzzzz_zzzz;
    assign wbus.instr_ready = 1'b1;
    assign wbus.redirect    = 1'b0;
    assign wbus.redirect_pc = '0;

    // Reference model: the queue contents as a list of {pc, instr}, plus the next fetch PC.
    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   ins;
    } ent_t;
    ent_t          mq[$];
    logic [AW-1:0] mpc;
    bit            model_ok = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mcheck();
        bit v, pop, fe;
        logic [31:0]   e_ins;
        logic [AW-1:0] e_pc;
        if (!model_ok) return;
        v     = (mq.size() != 0);
        pop   = v && bus.instr_ready;
        fe    = rst_n && !bus.redirect && ((mq.size() < DEPTH) || pop);
        e_ins = NOP;
        e_pc  = '0;
        if (v) begin
            e_ins = mq[0].ins;
            e_pc  = mq[0].pc;
        end
        chk("m_rom_cs", {31'd0, bus.rom_cs}, {31'd0, fe});
        chk("m_rom_addr", {19'd0, bus.rom_addr}, {19'd0, mpc});
        chk("m_valid", {31'd0, bus.instr_valid}, {31'd0, v});
        chk("m_instr", bus.instr_out, e_ins);
        chk("m_pc", {19'd0, bus.pc_out}, {19'd0, e_pc});
    endtask

    task automatic mupdate();
        bit pop, push;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            mpc      = '0;
            model_ok = 1'b1;
        end else if (bus.redirect) begin
            mq.delete();
            mpc = bus.redirect_pc & ~AW'(3);
        end else begin
            pop  = (mq.size() != 0) && bus.instr_ready;
            push = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc  = mpc;
                e.ins = romw(mpc);
                mq.push_back(e);
                mpc = mpc + AW'(4);
            end
        end
    endtask

    task automatic tick();
        #1 mcheck();
        @(posedge clk);
        mupdate();
        #1;
    endtask

    initial begin
        bit [15:0] rdy_pat;
        rst_n           = 1'b0;
        rom_key         = '0;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset for two cycles
        tick();
        #1;
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr_out, NOP);
        chk("rst_pc", {19'd0, bus.pc_out}, 32'd0);
        chk("rst_cs", {31'd0, bus.rom_cs}, 32'd0);
        chk("rst_addr", {19'd0, bus.rom_addr}, 32'd0);
        tick();

        // Stream with ready held high
        rst_n = 1'b1;
        #1;
        chk("s_cs", {31'd0, bus.rom_cs}, 32'd1);
        chk("s_addr0", {19'd0, bus.rom_addr}, 32'd0);
        chk("s_valid0", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        #1;
        chk("s_valid1", {31'd0, bus.instr_valid}, 32'd1);
        chk("s_pc0", {19'd0, bus.pc_out}, 32'h0000);
        chk("s_ins0", bus.instr_out, 32'h0000_0000);
        chk("w_pc0", {19'd0, wbus.pc_out}, 32'h1FF8);
        tick();
        #1;
        chk("s_pc1", {19'd0, bus.pc_out}, 32'h0004);
        chk("s_ins1", bus.instr_out, 32'h0000_0004);
        chk("w_pc1", {19'd0, wbus.pc_out}, 32'h1FFC);
        tick();
        #1;
        chk("s_pc2", {19'd0, bus.pc_out}, 32'h0008);
        chk("w_pc2", {19'd0, wbus.pc_out}, 32'h0000);
        tick();
        #1;
        chk("w_pc3", {19'd0, wbus.pc_out}, 32'h0004);
        tick();

        // Backpressure from reset
        rst_n = 1'b0;
        tick();
        rst_n           = 1'b1;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("bp_cs", {31'd0, bus.rom_cs}, 32'd0);
        chk("bp_addr", {19'd0, bus.rom_addr}, 32'h0008);
        chk("bp_ins", bus.instr_out, 32'h0000_0000);
        tick();
        tick();
        #1;
        chk("bp_hold_addr", {19'd0, bus.rom_addr}, 32'h0008);
        chk("bp_hold_ins", bus.instr_out, 32'h0000_0000);
        bus.instr_ready = 1'b1;
        #1;
        chk("bp_pop_cs", {31'd0, bus.rom_cs}, 32'd1);
        tick();
        #1;
        chk("bp_h1", bus.instr_out, 32'h0000_0004);
        tick();
        #1;
        chk("bp_h2", bus.instr_out, 32'h0000_0008);

        // Redirect while streaming at pc 0x0010
        for (int i = 0; i < 20 && bus.rom_addr != 13'h0010; i++) tick();
        chk("rd_reach", {19'd0, bus.rom_addr}, 32'h0010);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 13'h0103;
        #1;
        chk("rd_cs", {31'd0, bus.rom_cs}, 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("rd_addr", {19'd0, bus.rom_addr}, 32'h0100);
        chk("rd_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        #1;
        chk("rd_pc", {19'd0, bus.pc_out}, 32'h0100);
        chk("rd_ins", bus.instr_out, 32'h0000_0100);
        tick();
        tick();

        // Reset beats a simultaneous redirect with the queue full
        bus.instr_ready = 1'b0;
        tick();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 13'h0040;
        rst_n           = 1'b0;
        tick();
        #1;
        chk("rp_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rp_ins", bus.instr_out, NOP);
        chk("rp_addr", {19'd0, bus.rom_addr}, 32'h0000);
        bus.redirect = 1'b0;
        rst_n        = 1'b1;
        tick();

        // Full queue with continuous pop keeps fetching every cycle
        tick();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("fp_cs", {31'd0, bus.rom_cs}, 32'd1);
            tick();
        end

        // Mixed ready pattern, back-to-back redirects and PC wrap under a new ROM image
        rom_key = 32'hA5C3_0000;
        rdy_pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 16; i++) begin
            bus.instr_ready = rdy_pat[i];
            bus.redirect    = (i == 3) || (i == 4);
            bus.redirect_pc = (i == 3) ? 13'h1FF0 : 13'h1FF5;
            tick();
        end
        bus.redirect = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
